// File: rtl/probe_pattern_if.sv
// Write port, playback control and probe-bus outputs of the pattern generator.
// The driver uses master; the generator uses slave.
interface probe_pattern_if #(
  parameter int DATA_W     = 22,
  parameter int ADDR_W     = 8,
  parameter int LOOP_CNT_W = 16
);
  logic                  wr_en_i;
  logic [ADDR_W-1:0]     wr_addr_i;
  logic [DATA_W-1:0]     wr_data_i;
  logic [ADDR_W-1:0]     len_i;
  logic                  loop_i;
  logic                  start_i;
  logic                  stop_i;
  logic [DATA_W-1:0]     pattern_o;
  logic                  valid_o;
  logic                  busy_o;
  logic                  done_o;
  logic [LOOP_CNT_W-1:0] loop_cnt_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, len_i, loop_i, start_i, stop_i,
    input  pattern_o, valid_o, busy_o, done_o, loop_cnt_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, len_i, loop_i, start_i, stop_i,
    output pattern_o, valid_o, busy_o, done_o, loop_cnt_o
  );
endinterface

// File: rtl/probe_pattern_gen.sv
// Replays a stored word sequence from a dual-port pattern RAM onto the probe bus,
// once or continuously, with no bubbles between consecutive words or across a wrap.
module probe_pattern_gen #(
  parameter int DATA_W     = 22,
  parameter int ADDR_W     = 8,
  parameter int LOOP_CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  probe_pattern_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     len_q, len_d;
  logic                  loop_q, loop_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]     data_idx_q, data_idx_d;
  logic                  rd_done_q, rd_done_d;
  logic                  end_q, end_d;
  logic [DATA_W-1:0]     pattern_q, pattern_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [LOOP_CNT_W-1:0] loop_cnt_q, loop_cnt_d;
  logic                  rd_en;
  logic                  at_last;

  logic [DATA_W-1:0]     ram [2**ADDR_W];
  logic [DATA_W-1:0]     rd_data_q;

  // Read-before-write: a same-address collision returns the old word.
  always_ff @(posedge clk_i) begin
    if (bus.wr_en_i) ram[bus.wr_addr_i] <= bus.wr_data_i;
    if (rd_en)       rd_data_q <= ram[rd_addr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i && !bus.stop_i) state_d = PRIME;
      PRIME:   state_d = bus.stop_i ? IDLE : PLAY;
      PLAY:    if (bus.stop_i || end_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The read address runs one word ahead of pattern_o, so it wraps on its own
  // compare against len_q rather than on the output index.
  assign at_last = (rd_addr_q == len_q);

  always_comb begin
    len_d      = len_q;
    loop_d     = loop_q;
    rd_addr_d  = rd_addr_q;
    data_idx_d = data_idx_q;
    rd_done_d  = rd_done_q;
    end_d      = end_q;
    pattern_d  = pattern_q;
    loop_cnt_d = loop_cnt_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.stop_i) begin
          len_d      = bus.len_i;
          loop_d     = bus.loop_i;
          rd_addr_d  = '0;
          loop_cnt_d = '0;
          rd_done_d  = 1'b0;
          end_d      = 1'b0;
        end
      end
      PRIME, PLAY: begin
        if (!bus.stop_i) begin
          if (state_q == PLAY) begin
            if (end_q) begin
              done_d = 1'b1;
            end else begin
              valid_d   = 1'b1;
              pattern_d = rd_data_q;
              if (data_idx_q == len_q) begin
                if (loop_cnt_q != '1) loop_cnt_d = loop_cnt_q + 1'b1;
                end_d = !loop_q;
              end
            end
          end
          if (!rd_done_q && !end_q) begin
            rd_en      = 1'b1;
            data_idx_d = rd_addr_q;
            rd_addr_d  = at_last ? '0 : rd_addr_q + 1'b1;
            rd_done_d  = at_last && !loop_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q      <= '0;
      loop_q     <= 1'b0;
      rd_addr_q  <= '0;
      data_idx_q <= '0;
      rd_done_q  <= 1'b0;
      end_q      <= 1'b0;
      pattern_q  <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      loop_cnt_q <= '0;
    end else begin
      len_q      <= len_d;
      loop_q     <= loop_d;
      rd_addr_q  <= rd_addr_d;
      data_idx_q <= data_idx_d;
      rd_done_q  <= rd_done_d;
      end_q      <= end_d;
      pattern_q  <= pattern_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  always_comb begin
    bus.pattern_o  = pattern_q;
    bus.valid_o    = valid_q;
    bus.busy_o     = (state_q != IDLE);
    bus.done_o     = done_q;
    bus.loop_cnt_o = loop_cnt_q;
  end

endmodule

// File: tb/tb_probe_pattern_gen.sv
// Directed bench for probe_pattern_gen: a per-cycle vector table covering
// play-once, loop, single-word and write-collision runs, plus reset and full-depth sequences.
module tb_probe_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  probe_pattern_if bus ();
  probe_pattern_gen dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic        st, sp, lp, wr;
    logic [7:0]  ln, wa;
    logic [21:0] wd;
    logic        ev, eb, ed;
    logic [21:0] ep;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, sp, input logic [7:0] ln, input logic lp,
                              input logic wr, input logic [7:0] wa, input logic [21:0] wd,
                              input logic ev, eb, ed, input logic [21:0] ep, input logic [15:0] ec);
    vec_t v;
    v.st = st; v.sp = sp; v.ln = ln; v.lp = lp; v.wr = wr; v.wa = wa; v.wd = wd;
    v.ev = ev; v.eb = eb; v.ed = ed; v.ep = ep; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, eb, ed, input logic [21:0] ep,
                         input logic [15:0] ec);
    chk({nm, " valid"},    32'(bus.valid_o),    32'(ev));
    chk({nm, " busy"},     32'(bus.busy_o),     32'(eb));
    chk({nm, " done"},     32'(bus.done_o),     32'(ed));
    chk({nm, " pattern"},  32'(bus.pattern_o),  32'(ep));
    chk({nm, " loop_cnt"}, 32'(bus.loop_cnt_o), 32'(ec));
  endtask

  task automatic idle_inputs();
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.start_i = 1'b0; bus.stop_i = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [21:0] d);
    @(negedge clk);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = a; bus.wr_data_i = d;
    @(posedge clk);
    #1 bus.wr_en_i = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] ln, input logic lp);
    @(negedge clk);
    bus.len_i = ln; bus.loop_i = lp; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  initial begin
    logic [21:0] exp_w [4];
    int          nvalid;
    logic [21:0] first_w, last_w;
    logic        saw_done;

    idle_inputs();
    bus.len_i = '0; bus.loop_i = 1'b0;

    // Play once: len 3, loop 0
    tbl.push_back(mk(1,0,3,0, 0,0,0, 0,1,0,22'h0,       0));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 0,1,0,22'h0,       0));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 1,1,0,22'h000001,  0));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 1,1,0,22'h000002,  0));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 1,1,0,22'h0ABCDE,  0));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 1,1,0,22'h3FFFFF,  1));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 0,0,1,22'h3FFFFF,  1));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 0,0,0,22'h3FFFFF,  1));
    // Loop: len 1, loop 1; mid-run start with other settings is ignored; stop after 7 words
    tbl.push_back(mk(1,0,1,1, 0,0,0, 0,1,0,22'h3FFFFF,  0));
    tbl.push_back(mk(0,0,1,1, 0,0,0, 0,1,0,22'h3FFFFF,  0));
    tbl.push_back(mk(0,0,1,1, 0,0,0, 1,1,0,22'h000001,  0));
    tbl.push_back(mk(0,0,1,1, 0,0,0, 1,1,0,22'h000002,  1));
    tbl.push_back(mk(1,0,3,0, 0,0,0, 1,1,0,22'h000001,  1));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 1,1,0,22'h000002,  2));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 1,1,0,22'h000001,  2));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 1,1,0,22'h000002,  3));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 1,1,0,22'h000001,  3));
    tbl.push_back(mk(0,1,3,0, 0,0,0, 0,0,0,22'h000001,  3));
    tbl.push_back(mk(0,0,3,0, 0,0,0, 0,0,0,22'h000001,  3));
    // start+stop together in IDLE: nothing happens, count not cleared
    tbl.push_back(mk(1,1,2,1, 0,0,0, 0,0,0,22'h000001,  3));
    tbl.push_back(mk(0,0,2,1, 0,0,0, 0,0,0,22'h000001,  3));
    // Single word repeating: len 0, loop 1
    tbl.push_back(mk(1,0,0,1, 0,0,0, 0,1,0,22'h000001,  0));
    tbl.push_back(mk(0,0,0,1, 0,0,0, 0,1,0,22'h000001,  0));
    tbl.push_back(mk(0,0,0,1, 0,0,0, 1,1,0,22'h000001,  1));
    tbl.push_back(mk(0,0,0,1, 0,0,0, 1,1,0,22'h000001,  2));
    tbl.push_back(mk(0,0,0,1, 0,0,0, 1,1,0,22'h000001,  3));
    tbl.push_back(mk(0,1,0,1, 0,0,0, 0,0,0,22'h000001,  3));
    // Write collision on RAM[2] while it is being read
    tbl.push_back(mk(1,0,3,1, 0,0,0,            0,1,0,22'h000001, 0));
    tbl.push_back(mk(0,0,3,1, 0,0,0,            0,1,0,22'h000001, 0));
    tbl.push_back(mk(0,0,3,1, 0,0,0,            1,1,0,22'h000001, 0));
    tbl.push_back(mk(0,0,3,1, 1,2,22'h155555,   1,1,0,22'h000002, 0));
    tbl.push_back(mk(0,0,3,1, 0,0,0,            1,1,0,22'h0ABCDE, 0));
    tbl.push_back(mk(0,0,3,1, 0,0,0,            1,1,0,22'h3FFFFF, 1));
    tbl.push_back(mk(0,0,3,1, 0,0,0,            1,1,0,22'h000001, 1));
    tbl.push_back(mk(0,0,3,1, 0,0,0,            1,1,0,22'h000002, 1));
    tbl.push_back(mk(0,0,3,1, 0,0,0,            1,1,0,22'h155555, 1));
    tbl.push_back(mk(0,0,3,1, 0,0,0,            1,1,0,22'h3FFFFF, 2));
    tbl.push_back(mk(0,1,3,1, 0,0,0,            0,0,0,22'h3FFFFF, 2));

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_out("reset_held", 0, 0, 0, 22'h0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk_out("reset_release", 0, 0, 0, 22'h0, 0);

    write_word(8'd0, 22'h000001);
    write_word(8'd1, 22'h000002);
    write_word(8'd2, 22'h0ABCDE);
    write_word(8'd3, 22'h3FFFFF);

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.start_i = tbl[i].st; bus.stop_i = tbl[i].sp;
      bus.len_i = tbl[i].ln;   bus.loop_i = tbl[i].lp;
      bus.wr_en_i = tbl[i].wr; bus.wr_addr_i = tbl[i].wa; bus.wr_data_i = tbl[i].wd;
      @(posedge clk);
      #1 chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eb, tbl[i].ed, tbl[i].ep, tbl[i].ec);
    end
    @(negedge clk) idle_inputs();

    // Asynchronous reset mid-run, then replay from word 0 with RAM intact
    start_run(8'd3, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("prereset valid", 32'(bus.valid_o), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_out("async_reset", 0, 0, 0, 22'h0, 0);
    @(negedge clk) rst = 1'b0;
    exp_w[0] = 22'h000001; exp_w[1] = 22'h000002; exp_w[2] = 22'h155555; exp_w[3] = 22'h3FFFFF;
    start_run(8'd3, 1'b0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk_out($sformatf("replay%0d", k), 1, 1, 0, exp_w[k], (k == 3) ? 16'd1 : 16'd0);
    end
    @(posedge clk);
    #1 chk_out("replay_done", 0, 0, 1, 22'h3FFFFF, 1);

    // Full-depth play: 256 words without early stop at the natural address wrap
    write_word(8'd255, 22'h2AAAAA);
    start_run(8'd255, 1'b0);
    nvalid = 0; first_w = '0; last_w = '0; saw_done = 1'b0;
    for (int c = 0; c < 300 && !saw_done; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) begin
        if (nvalid == 0) first_w = bus.pattern_o;
        last_w = bus.pattern_o;
        nvalid++;
      end
      if (bus.done_o) saw_done = 1'b1;
    end
    chk("full done_seen",   32'(saw_done),       32'd1);
    chk("full word_count",  32'(nvalid),         32'd256);
    chk("full first_word",  32'(first_w),        32'h000001);
    chk("full last_word",   32'(last_w),         32'h2AAAAA);
    chk("full loop_cnt",    32'(bus.loop_cnt_o), 32'd1);
    chk("full busy_after",  32'(bus.busy_o),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
